// File: rtl/errcnt_pkg.sv
// Shared definitions for the error counter bank: sum FSM states, default widths
// and the saturation-max helper.
package errcnt_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_LATCH = 2'd2
  } sum_state_t;

  localparam int DEF_NUM_CH     = 16;
  localparam int DEF_CNT_W      = 32;
  localparam int DEF_SUM_W      = 38;
  localparam int DEF_WINDOW_OPS = 1000;
  localparam int DEF_RATE_W     = 8;

  // All-ones value of a given width (widths above 64 clamp to 64 bits).
  function automatic logic [63:0] sat_max(input int width);
    if (width >= 64) begin
      sat_max = {64{1'b1}};
    end else begin
      sat_max = (64'd1 << width) - 64'd1;
    end
  endfunction

endpackage

// File: rtl/errcnt_sat_channel.sv
// One saturating error counter; clear beats a same-cycle strobe.
module errcnt_sat_channel
  import errcnt_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             strobe,
  output logic [CNT_W-1:0] count
);

  localparam logic [63:0]      MAX_64 = sat_max(CNT_W);
  localparam logic [CNT_W-1:0] MAX_V  = MAX_64[CNT_W-1:0];

  // Counter state: reset > clear > saturating increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (strobe && (count != MAX_V)) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/error_counter_bank.sv
// N-channel lifetime error counter bank with readout, rolling total, windowed rate
// and alarm. Optional shadow-bank snapshot readout under ERRCNT_SNAPSHOT_EN.
module error_counter_bank
  import errcnt_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SUM_W      = DEF_SUM_W,
  parameter int WINDOW_OPS = DEF_WINDOW_OPS,
  parameter int RATE_W     = DEF_RATE_W,
  localparam int IDX_W     = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] err_strobe,
  input  logic              clear_all,
  input  logic [NUM_CH-1:0] clear_mask,
  input  logic              op_done,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [CNT_W-1:0]  rd_data,
  output logic [SUM_W-1:0]  total_errors,
  output logic              total_valid,
  output logic              any_error,
  output logic [RATE_W-1:0] error_rate,
  input  logic [RATE_W-1:0] rate_thresh,
`ifdef ERRCNT_SNAPSHOT_EN
  input  logic              snap_req,
  output logic              snap_done,
`endif
  output logic              rate_alarm
);

  localparam int               POP_W    = $clog2(NUM_CH + 1);
  localparam int               WS_W     = ((RATE_W > POP_W) ? RATE_W : POP_W) + 1;
  localparam int               OPS_W    = $clog2(WINDOW_OPS + 1);
  localparam logic [63:0]      RATE_64  = sat_max(RATE_W);
  localparam logic [RATE_W-1:0] RATE_MAX = RATE_64[RATE_W-1:0];

  logic [CNT_W-1:0]  cnt_s    [NUM_CH];
  logic [CNT_W-1:0]  rd_src_s [NUM_CH];
  logic [NUM_CH-1:0] nz_s;
  logic [POP_W-1:0]  pop_s;
  logic [WS_W-1:0]   win_sum_s;
  logic [RATE_W-1:0] win_next_s;

  sum_state_t        state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [SUM_W-1:0]  acc_r;
  logic [OPS_W-1:0]  ops_r;
  logic [RATE_W-1:0] win_r;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    errcnt_sat_channel #(.CNT_W(CNT_W)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .clr    (clear_all | clear_mask[i]),
      .strobe (err_strobe[i]),
      .count  (cnt_s[i])
    );
    assign nz_s[i] = |cnt_s[i];
  end

`ifdef ERRCNT_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow_r [NUM_CH];

  // Shadow bank captures the pre-increment counters so software reads never tear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) shadow_r[i] <= '0;
      snap_done <= 1'b0;
    end else if (snap_req) begin
      for (int i = 0; i < NUM_CH; i++) shadow_r[i] <= cnt_s[i];
      snap_done <= 1'b1;
    end else begin
      snap_done <= 1'b0;
    end
  end

  assign rd_src_s = shadow_r;
`else
  assign rd_src_s = cnt_s;
`endif

  // Indexed readout and any-error flag, both one cycle behind the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data   <= '0;
      any_error <= 1'b0;
    end else begin
      any_error <= |nz_s;
      if (int'(rd_idx) < NUM_CH) begin
        rd_data <= rd_src_s[rd_idx];
      end else begin
        rd_data <= '0;
      end
    end
  end

  // Sequential total: one channel per cycle, aborted by any clear mid-pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      idx_r        <= '0;
      acc_r        <= '0;
      total_errors <= '0;
      total_valid  <= 1'b0;
    end else begin
      total_valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          acc_r   <= '0;
          idx_r   <= '0;
          state_r <= S_ACC;
        end
        S_ACC: begin
          if (clear_all || (|clear_mask)) begin
            state_r <= S_IDLE;
          end else begin
            acc_r <= acc_r + SUM_W'(cnt_s[idx_r]);
            if (idx_r == IDX_W'(NUM_CH - 1)) begin
              state_r <= S_LATCH;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        S_LATCH: begin
          if (!clear_all) begin
            total_errors <= acc_r;
            total_valid  <= 1'b1;
          end
          state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
      if (clear_all) total_errors <= '0;
    end
  end

  // Strobe popcount and saturating window accumulation.
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < NUM_CH; i++) pop_s = pop_s + POP_W'(err_strobe[i]);
    win_sum_s = WS_W'(win_r) + WS_W'(pop_s);
    if (win_sum_s > WS_W'(RATE_MAX)) begin
      win_next_s = RATE_MAX;
    end else begin
      win_next_s = win_sum_s[RATE_W-1:0];
    end
  end

  // Rate window; the closing op's strobes belong to the window being published.
  always_ff @(posedge clk) begin
    if (reset) begin
      ops_r      <= '0;
      win_r      <= '0;
      error_rate <= '0;
      rate_alarm <= 1'b0;
    end else begin
      rate_alarm <= (rate_thresh != '0) && (error_rate >= rate_thresh);
      if (clear_all) begin
        ops_r <= '0;
        win_r <= '0;
      end else if (op_done && (ops_r == OPS_W'(WINDOW_OPS - 1))) begin
        error_rate <= win_next_s;
        ops_r      <= '0;
        win_r      <= '0;
      end else if (op_done) begin
        ops_r <= ops_r + OPS_W'(1);
        win_r <= win_next_s;
      end else begin
        win_r <= win_next_s;
      end
    end
  end

endmodule
